// File: rtl/jt12_clksync_fifo_if.sv
// Bus bundle for jt12_clksync_fifo: CPU-side register bus plus the
// synthesizer-side write/status signals. slave = bridge, master = host/synth.
interface jt12_clksync_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic [DW-1:0] cpu_din;
    logic [AW-1:0] cpu_addr;
    logic          cpu_cs_n;
    logic          cpu_wr_n;
    logic [7:0]    cpu_dout;
    logic          cpu_irq_n;
    logic [DW-1:0] syn_din;
    logic [AW-1:0] syn_addr;
    logic          syn_write;
    logic          syn_rst;
    logic          syn_busy;
    logic          syn_flag_A;
    logic          syn_flag_B;
    logic          syn_irq_n;

    modport slave (
        input  cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n,
        input  syn_busy, syn_flag_A, syn_flag_B, syn_irq_n,
        output cpu_dout, cpu_irq_n,
        output syn_din, syn_addr, syn_write, syn_rst
    );

    modport master (
        output cpu_din, cpu_addr, cpu_cs_n, cpu_wr_n,
        output syn_busy, syn_flag_A, syn_flag_B, syn_irq_n,
        input  cpu_dout, cpu_irq_n,
        input  syn_din, syn_addr, syn_write, syn_rst
    );
endinterface

// File: rtl/jt12_clksync_fifo.sv
// CPU-to-synth clock-domain bridge: buffers CPU register writes in a FIFO and
// hands them one at a time to the syn_clk domain with a toggle handshake.
// Ports: rst (async, high), cpu_clk, syn_clk, bus (slave: CPU bus in,
// status/IRQ out; synth write bus out, busy/flags/IRQ in).
module jt12_clksync_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 rst,
    input  logic                 cpu_clk,
    input  logic                 syn_clk,
    jt12_clksync_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int EW    = AW + DW;
    localparam logic [FIFO_LOG2:0] PONE = 1;

    typedef enum logic [1:0] {IDLE, REQ, ACK_WAIT, BUSY_WAIT} state_t;

    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_LOG2:0] wp, rp;
    logic               wr_last, rd_last, ovf;
    logic [1:0]         ack_sy, busy_sy, fa_sy, fb_sy, irq_sy;
    state_t             st;
    logic               req_t, seen_busy;
    logic [5:0]         tmr;
    logic [EW-1:0]      hold;

    logic wr_act, rd_act, wr_edge, rd_edge;
    logic empty, full, pop, push, cpu_busy;
    logic ack_s, busy_s;

    assign wr_act  = !bus.cpu_cs_n && !bus.cpu_wr_n;
    assign rd_act  = !bus.cpu_cs_n &&  bus.cpu_wr_n;
    assign wr_edge = wr_act && !wr_last;
    assign rd_edge = rd_act && !rd_last;

    assign empty = wp == rp;
    assign full  = (wp[FIFO_LOG2] != rp[FIFO_LOG2]) &&
                   (wp[FIFO_LOG2-1:0] == rp[FIFO_LOG2-1:0]);
    // The head leaves the FIFO in REQ, so a write in that cycle still fits.
    assign pop   = st == REQ;
    assign push  = wr_edge && (!full || pop);

    assign ack_s    = ack_sy[1];
    assign busy_s   = busy_sy[1];
    assign cpu_busy = !empty || (st != IDLE);

    assign bus.cpu_dout  = bus.cpu_cs_n ? 8'hFF :
                           {cpu_busy, ovf, 4'b0, fb_sy[1], fa_sy[1]};
    assign bus.cpu_irq_n = irq_sy[1];

    always_ff @(posedge cpu_clk) begin
        if (push) mem[wp[FIFO_LOG2-1:0]] <= {bus.cpu_addr, bus.cpu_din};
    end

    logic ack_t;

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            wr_last   <= 1'b0;
            rd_last   <= 1'b0;
            ovf       <= 1'b0;
            ack_sy    <= 2'b00;
            busy_sy   <= 2'b00;
            fa_sy     <= 2'b00;
            fb_sy     <= 2'b00;
            irq_sy    <= 2'b11;
            st        <= IDLE;
            req_t     <= 1'b0;
            seen_busy <= 1'b0;
            tmr       <= '0;
            hold      <= '0;
        end else begin
            wr_last <= wr_act;
            rd_last <= rd_act;
            ack_sy  <= {ack_sy[0], ack_t};
            busy_sy <= {busy_sy[0], bus.syn_busy};
            fa_sy   <= {fa_sy[0], bus.syn_flag_A};
            fb_sy   <= {fb_sy[0], bus.syn_flag_B};
            irq_sy  <= {irq_sy[0], bus.syn_irq_n};
            if (push) wp <= wp + PONE;
            if (wr_edge && full && !pop) ovf <= 1'b1;
            else if (rd_edge)            ovf <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (!empty && !busy_s) st <= REQ;
                end
                REQ: begin
                    hold  <= mem[rp[FIFO_LOG2-1:0]];
                    rp    <= rp + PONE;
                    req_t <= ~req_t;
                    st    <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (ack_s != req_t) begin
                        seen_busy <= 1'b0;
                        tmr       <= '0;
                        st        <= BUSY_WAIT;
                    end
                end
                BUSY_WAIT: begin
                    tmr <= tmr + 6'd1;
                    if (busy_s) seen_busy <= 1'b1;
                    // A short busy pulse may never reach cpu_clk; the
                    // timer keeps the bridge from stalling on it.
                    if ((seen_busy && !busy_s) || tmr == 6'd63) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    // syn_rst: asserted with rst, released cleanly on a syn_clk negedge.
    logic [1:0] rst_sh;
    logic       syn_rst;

    always_ff @(negedge syn_clk or posedge rst) begin
        if (rst) rst_sh <= 2'b11;
        else     rst_sh <= {rst_sh[0], 1'b0};
    end

    assign syn_rst     = rst_sh[1];
    assign bus.syn_rst = syn_rst;

    logic [1:0]    req_sy;
    logic          req_last, syn_write_r, req_chg;
    logic [AW-1:0] syn_addr_r;
    logic [DW-1:0] syn_din_r;

    assign req_chg = req_sy[1] ^ req_last;

    always_ff @(posedge syn_clk or posedge syn_rst) begin
        if (syn_rst) begin
            req_sy      <= 2'b00;
            req_last    <= 1'b0;
            ack_t       <= 1'b0;
            syn_write_r <= 1'b0;
            syn_addr_r  <= '0;
            syn_din_r   <= '0;
        end else begin
            req_sy      <= {req_sy[0], req_t};
            req_last    <= req_sy[1];
            syn_write_r <= req_chg;
            if (req_chg) begin
                {syn_addr_r, syn_din_r} <= hold;
                ack_t <= ~ack_t;
            end
        end
    end

    assign bus.syn_write = syn_write_r;
    assign bus.syn_addr  = syn_addr_r;
    assign bus.syn_din   = syn_din_r;
endmodule

// File: tb/tb_jt12_clksync_fifo.sv
// Self-checking bench for jt12_clksync_fifo: random CPU writes scored
// against an in-order queue of expected synth writes, plus directed cases.
module tb_jt12_clksync_fifo;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int FL = 2;

    logic rst = 1'b1;
    logic cpu_clk = 1'b0;
    logic syn_clk = 1'b0;
    int   cpu_half = 5;
    int   syn_half = 5;

    always #(cpu_half) cpu_clk = ~cpu_clk;
    always #(syn_half) syn_clk = ~syn_clk;

    jt12_clksync_fifo_if #(.DW(DW), .AW(AW)) bus();

    jt12_clksync_fifo #(.DW(DW), .AW(AW), .FIFO_LOG2(FL)) dut (
        .rst(rst),
        .cpu_clk(cpu_clk),
        .syn_clk(syn_clk),
        .bus(bus)
    );

    int checks = 0;
    int fails = 0;
    int delivered = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic hold_busy = 1'b0;
    int busy_len = 3;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard: every syn_write must be the oldest accepted CPU write.
    initial begin
        logic [AW+DW-1:0] e;
        logic prev_wr;
        prev_wr = 1'b0;
        forever begin
            @(negedge syn_clk);
            if (bus.syn_write === 1'b1) begin
                checks++;
                if (prev_wr) begin
                    fails++;
                    $display("FAIL syn_write_gap: two adjacent pulses");
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL syn_write_extra: got %0h expected none",
                             {bus.syn_addr, bus.syn_din});
                end else begin
                    e = exp_q.pop_front();
                    delivered++;
                    if ({bus.syn_addr, bus.syn_din} !== e) begin
                        fails++;
                        $display("FAIL syn_write_data: got %0h expected %0h",
                                 {bus.syn_addr, bus.syn_din}, e);
                    end
                end
            end
            prev_wr = bus.syn_write;
        end
    end

    // Synth model: busy for busy_len syn_clk after each accepted write.
    initial begin
        int cnt;
        cnt = 0;
        bus.syn_busy = 1'b0;
        forever begin
            @(negedge syn_clk);
            if (bus.syn_write === 1'b1) cnt = busy_len;
            else if (cnt > 0)           cnt--;
            bus.syn_busy = hold_busy || (cnt > 0);
        end
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int len, input bit accepted);
        if (accepted) exp_q.push_back({a, d});
        @(posedge cpu_clk); #1;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b0;
        repeat (len) @(posedge cpu_clk);
        #1;
        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
    endtask

    task automatic cpu_read(output logic [7:0] v);
        @(posedge cpu_clk); #1;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b1;
        #1;
        v = bus.cpu_dout;
        @(posedge cpu_clk); #1;
        bus.cpu_cs_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge cpu_clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (6) @(posedge syn_clk);
    endtask

    task automatic wait_idle(input string name);
        logic [7:0] v;
        int n;
        n = 0;
        v = 8'hFF;
        while (n < 300) begin
            cpu_read(v);
            if (!v[7]) break;
            n++;
        end
        check(name, v[7], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int d0, total;
        int ch [3];
        int sh [3];
        ch[0] = 5;  sh[0] = 15;
        ch[1] = 15; sh[1] = 5;
        ch[2] = 7;  sh[2] = 5;

        bus.cpu_cs_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_addr = '0;
        bus.cpu_din = '0;
        bus.syn_flag_A = 1'b0;
        bus.syn_flag_B = 1'b0;
        bus.syn_irq_n = 1'b1;

        // Reset state
        repeat (3) @(posedge cpu_clk);
        #1;
        check("rst_dout_desel", bus.cpu_dout, 8'hFF);
        check("rst_syn_rst", bus.syn_rst, 1);
        check("rst_syn_write", bus.syn_write, 0);
        check("rst_syn_bus", {bus.syn_addr, bus.syn_din}, 0);
        check("rst_irq", bus.cpu_irq_n, 1);
        bus.cpu_cs_n = 1'b0;
        #1;
        check("rst_dout_sel", bus.cpu_dout, 8'h00);
        bus.cpu_cs_n = 1'b1;
        @(posedge syn_clk); #1;
        rst = 1'b0;
        @(negedge syn_clk); #1;
        check("syn_rst_neg1", bus.syn_rst, 1);
        @(negedge syn_clk); #1;
        check("syn_rst_neg2", bus.syn_rst, 0);
        repeat (5) @(posedge cpu_clk);

        // Single write
        busy_len = 3;
        cpu_write(2'd1, 8'h2A, 1, 1'b1);
        cpu_read(v);
        check("single_busy", v[7], 1);
        check("single_ovf", v[6], 0);
        wait_drain("single_drain");
        check("single_count", delivered, 1);
        wait_idle("single_idle");

        // Burst of four, hold the write low for varying lengths
        d0 = delivered;
        for (int i = 0; i < 4; i++)
            cpu_write(AW'(i), 8'h10 + 8'(i), 1 + (i % 3), 1'b1);
        wait_drain("burst_drain");
        check("burst_count", delivered - d0, 4);
        cpu_read(v);
        check("burst_ovf", v[6], 0);
        wait_idle("burst_idle");

        // Overflow: synth busy, fifth write dropped
        hold_busy = 1'b1;
        repeat (8) @(posedge cpu_clk);
        d0 = delivered;
        for (int i = 0; i < 5; i++)
            cpu_write(AW'(i), 8'h20 + 8'(i), 1, i < 4);
        cpu_read(v);
        check("ovf_set", v[7:6], 2'b11);
        cpu_read(v);
        check("ovf_clear", v[6], 0);
        repeat (20) @(posedge cpu_clk);
        check("ovf_held", delivered - d0, 0);
        hold_busy = 1'b0;
        wait_drain("ovf_drain");
        check("ovf_count", delivered - d0, 4);
        wait_idle("ovf_idle");

        // Clock ratio sweep with random writes
        d0 = delivered;
        total = 0;
        for (int r = 0; r < 3; r++) begin
            cpu_half = ch[r];
            syn_half = sh[r];
            repeat (4) @(posedge cpu_clk);
            for (int b = 0; b < 5; b++) begin
                int n;
                n = $urandom_range(1, 4);
                busy_len = $urandom_range(1, 4);
                for (int j = 0; j < n; j++) begin
                    cpu_write(AW'($urandom_range(0, 3)),
                              DW'($urandom_range(0, 255)),
                              $urandom_range(1, 3), 1'b1);
                    repeat ($urandom_range(0, 3)) @(posedge cpu_clk);
                    total++;
                end
                wait_drain("sweep_drain");
            end
        end
        check("sweep_count", delivered - d0, total);

        // Reset during ACK_WAIT
        cpu_half = 5;
        syn_half = 20;
        busy_len = 3;
        repeat (4) @(posedge syn_clk);
        d0 = delivered;
        cpu_write(2'd2, 8'h55, 1, 1'b0);
        repeat (2) @(posedge cpu_clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_syn_rst", bus.syn_rst, 1);
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b1;
        #1;
        check("mid_dout_sel", bus.cpu_dout, 8'h00);
        bus.cpu_cs_n = 1'b1;
        repeat (3) @(posedge cpu_clk);
        @(posedge syn_clk); #1;
        rst = 1'b0;
        @(negedge syn_clk); #1;
        check("mid_rel_neg1", bus.syn_rst, 1);
        @(negedge syn_clk); #1;
        check("mid_rel_neg2", bus.syn_rst, 0);
        repeat (20) @(posedge syn_clk);
        check("mid_no_write", delivered - d0, 0);
        cpu_read(v);
        check("mid_empty", v[7], 0);
        cpu_write(2'd3, 8'h66, 1, 1'b1);
        wait_drain("mid_resume");
        check("mid_resume_count", delivered - d0, 1);

        // Flags and IRQ
        syn_half = 5;
        @(posedge cpu_clk); #1;
        bus.syn_flag_A = 1'b1;
        bus.syn_irq_n = 1'b0;
        repeat (3) @(posedge cpu_clk);
        #1;
        check("irq_low", bus.cpu_irq_n, 0);
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b1;
        #1;
        check("flag_a", bus.cpu_dout[1:0], 2'b01);
        bus.cpu_cs_n = 1'b1;
        bus.syn_flag_A = 1'b0;
        bus.syn_flag_B = 1'b1;
        bus.syn_irq_n = 1'b1;
        repeat (3) @(posedge cpu_clk);
        #1;
        check("irq_high", bus.cpu_irq_n, 1);
        bus.cpu_cs_n = 1'b0;
        #1;
        check("flag_b", bus.cpu_dout[1:0], 2'b10);
        bus.cpu_cs_n = 1'b1;

        repeat (10) @(posedge cpu_clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/jt12_clksync_fifo.md
JT12_CLKSYNC_FIFO -- requirements
Module: jt12_clksync_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, meaning CPU/synth data width.
REQ-002 SHALL have parameter AW, default 2, meaning register address width.
REQ-003 SHALL have parameter FIFO_LOG2, default 2, meaning write-FIFO depth of 2**FIFO_LOG2 entries.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port cpu_clk, input, 1, CPU-domain clock.
REQ-006 SHALL have port syn_clk, input, 1, synthesizer-domain clock, asynchronous to cpu_clk.
REQ-007 SHALL have ports cpu_din (input, DW), cpu_addr (input, AW), cpu_cs_n (input, 1) and cpu_wr_n (input, 1), meaning CPU bus.
REQ-008 SHALL have port cpu_dout, output, 8, status byte.
REQ-009 SHALL have port cpu_irq_n, output, 1, synchronised IRQ.
REQ-010 SHALL have ports syn_din (output, DW), syn_addr (output, AW), syn_write (output, 1) and syn_rst (output, 1), all in the syn_clk domain.
REQ-011 SHALL have ports syn_busy, syn_flag_A, syn_flag_B and syn_irq_n, each input, 1, in the syn_clk domain.

Function
REQ-012 SHALL detect a write on the rising edge of (!cpu_cs_n && !cpu_wr_n), sampled at posedge cpu_clk; one push per low phase, regardless of phase length.
REQ-013 SHALL push {cpu_addr, cpu_din} into the FIFO on the detected edge when the FIFO is not full.
REQ-014 SHALL drop the write when the FIFO is full, set sticky bit ovf, and leave FIFO contents unchanged.
REQ-015 SHALL handle a push and a pop in the same cycle by updating both pointers, leaving count unchanged; this includes the full case, where the pop frees the slot and the push is accepted.
REQ-016 SHALL use pointers of FIFO_LOG2+1 bits with wrap-around: empty when the pointers are equal, full when the MSBs differ and the rest are equal.
REQ-017 SHALL run the drain FSM in cpu_clk with states IDLE, REQ, ACK_WAIT and BUSY_WAIT.
REQ-018 SHALL move the drain FSM IDLE->REQ when the FIFO is not empty and busy_s==0.
REQ-019 SHALL, in REQ, pop the head into hold registers, toggle req_t, and go to ACK_WAIT (one cycle).
REQ-020 SHALL move ACK_WAIT->BUSY_WAIT when ack_s != req_t.
REQ-021 SHALL move BUSY_WAIT->IDLE after busy_s has been seen 1 then 0, or after 64 cpu_clk timeout.
REQ-022 SHALL keep the hold registers stable from REQ until ACK_WAIT exits.
REQ-023 SHALL synchronise req_t into syn_clk with a 2-FF synchroniser.
REQ-024 SHALL, on a change of the synchronised req_t, latch the hold registers into syn_addr/syn_din, pulse syn_write high for exactly one syn_clk, and toggle ack_t.
REQ-025 SHALL synchronise ack_t back to cpu_clk through 2 FFs, producing ack_s.
REQ-026 SHALL synchronise syn_busy, syn_flag_A, syn_flag_B and syn_irq_n to cpu_clk through 2 FFs each (busy_s, fa_s, fb_s, irq_s).
REQ-027 SHALL set cpu_busy = (FIFO not empty) || (FSM != IDLE).
REQ-028 SHALL drive cpu_dout = 8'hFF when cpu_cs_n==1, else {cpu_busy, ovf, 4'b0, fb_s, fa_s}.
REQ-029 SHALL clear ovf one cycle after a status read (cs_n low with wr_n high, rising edge detected).
REQ-030 SHALL drive cpu_irq_n = irq_s.
REQ-031 SHALL deliver writes to the synth in FIFO order, one at a time, never two syn_write pulses without an intervening handshake.

Reset
REQ-032 SHALL, while rst is high, clear the FIFO pointers, set the FSM to IDLE, and clear ovf, req_t, ack_t and the write-edge detector.
REQ-033 SHALL, while rst is high, reset all synchronisers to 0, except irq_s which resets to 1.
REQ-034 SHALL, while rst is high, hold cpu_dout at 8'hFF when deselected and at 8'h00 when selected.
REQ-035 SHALL, while rst is high, hold syn_write, syn_din and syn_addr at 0 and syn_rst at 1.
REQ-036 SHALL deassert syn_rst on the second negedge syn_clk after rst falls, via a 2-stage shift.
REQ-037 SHALL handle rst asserted mid-transfer by aborting immediately, discarding pending entries, and emitting no further syn_write pulses after release until new CPU writes arrive.

Verification
REQ-038 SHALL cover single write: addr=1, din=8'h2A, syn_busy pulsed for 3 syn_clk -> one syn_write pulse, syn_addr=1, syn_din=8'h2A, and cpu_dout[7] returns to 0 after busy_s falls.
REQ-039 SHALL cover burst: 4 back-to-back writes 8'h10..8'h13 with FIFO_LOG2=2 -> four syn_write pulses, in order, each delivered after syn_busy clears; ovf=0.
REQ-040 SHALL cover overflow: 5 writes with syn_busy held 1 -> fifth dropped, cpu_dout[6]=1, first four delivered after syn_busy drops, and ovf cleared after a status read.
REQ-041 SHALL cover clock ratio sweep: cpu_clk:syn_clk of 1:3, 3:1 and 7:5 with random writes -> scoreboard matches, no lost or duplicated syn_write.
REQ-042 SHALL cover reset mid-transfer: rst during ACK_WAIT -> syn_rst=1, FIFO empty, cpu_dout=8'h00 while selected, and syn_rst=0 on the second syn_clk negedge after release.
REQ-043 SHALL cover flags and IRQ: syn_flag_A=1 and syn_irq_n=0 -> cpu_dout[0]=1 and cpu_irq_n=0 within 3 cpu_clk.
